// File: rtl/inst_prefetch_buffer_if.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buffer_if
// Bundles the instruction-memory request channel, the CPU redirect inputs and
// the CPU-facing instruction queue head into one interface.
//   master modport : the prefetch buffer (drives mem_req/mem_addr and the
//                    inst_* / count outputs)
//   slave modport  : the environment (instruction memory + CPU fetch port)
// Signals:
//   mem_req, mem_addr[31:0]       fetch request and word address
//   mem_ack, mem_rdata[31:0]      memory response
//   redirect, redirect_pc[31:0]   taken branch/jump restart
//   inst_valid, inst, inst_pc     queue head presented to the CPU
//   inst_ready                    CPU consumes the head
//   count                         queue occupancy
// ---------------------------------------------------------------------------
interface inst_prefetch_buffer_if #(
  parameter int unsigned DEPTH = 4
) ();
  logic                       mem_req;
  logic [31:0]                mem_addr;
  logic                       mem_ack;
  logic [31:0]                mem_rdata;
  logic                       redirect;
  logic [31:0]                redirect_pc;
  logic                       inst_valid;
  logic [31:0]                inst;
  logic [31:0]                inst_pc;
  logic                       inst_ready;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc, count,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, count,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buffer
// Sequential instruction prefetcher sitting in front of the CPU fetch port.
// Issues one word request at a time to a slow instruction memory, queues the
// returned words with their PCs in a DEPTH-entry FIFO and presents the head
// with valid/ready. A redirect flushes the queue and restarts fetch at the
// (word-aligned) target; a response already in flight is dropped.
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   bus (master)        memory channel, redirect inputs, queue head, count
//   stat_fetch[15:0]    words pushed, saturating      (PREFETCH_STATS_EN only)
//   stat_discard[15:0]  responses dropped, saturating (PREFETCH_STATS_EN only)
// Optional feature macro: PREFETCH_STATS_EN
// ---------------------------------------------------------------------------
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_prefetch_buffer_if.master bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]            stat_fetch,
  output logic [15:0]            stat_discard
`endif
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_r;
  logic          mem_req_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fifo_inst_r [DEPTH];
  logic [31:0]   fifo_pc_r   [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic          ack_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic          valid_s;
  logic          slot_free_s;
  logic [CW-1:0] count_next_s;
  logic [31:0]   redir_pc_s;
  logic [31:0]   pc_plus4_s;

  // Handshake events and the occupancy seen after the coming edge
  always_comb begin
    valid_s    = (count_r != {CW{1'b0}});
    redir_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
    pc_plus4_s = fetch_pc_r + 32'd4;
    ack_s      = bus.mem_ack & mem_req_r;
    push_s     = ack_s & (state_r == ST_REQ) & ~bus.redirect;
    drop_s     = ack_s & ((state_r == ST_DISCARD) | bus.redirect);
    pop_s      = valid_s & bus.inst_ready & ~bus.redirect;
    if (bus.redirect) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    end
    // A new request reserves one slot on top of the post-edge occupancy
    slot_free_s = (count_next_s < CW'(DEPTH));
  end

  // Fetch FSM: owns mem_req, mem_addr and the next sequential fetch PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= START_PC;
      fetch_pc_r <= START_PC;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Redirect while idle only retargets; issue happens next cycle
          if (bus.redirect) begin
            fetch_pc_r <= redir_pc_s;
          end else if (slot_free_s) begin
            state_r    <= ST_REQ;
            mem_req_r  <= 1'b1;
            mem_addr_r <= fetch_pc_r;
          end
        end
        ST_REQ: begin
          if (bus.redirect) begin
            fetch_pc_r <= redir_pc_s;
            if (ack_s) begin
              state_r   <= ST_IDLE;
              mem_req_r <= 1'b0;
            end else begin
              // Request must stay stable until acked; its data is dropped
              state_r <= ST_DISCARD;
            end
          end else if (ack_s) begin
            fetch_pc_r <= pc_plus4_s;
            if (slot_free_s) begin
              mem_addr_r <= pc_plus4_s;
            end else begin
              state_r   <= ST_IDLE;
              mem_req_r <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (bus.redirect) begin
            fetch_pc_r <= redir_pc_s;
          end
          if (ack_s) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect flush overrides push and pop
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
    end
  end

  // FIFO storage: word plus the address it was fetched from
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_inst_r[wr_ptr_r] <= bus.mem_rdata;
      fifo_pc_r[wr_ptr_r]   <= mem_addr_r;
    end
  end

`ifdef PREFETCH_STATS_EN
  // Saturating fetch/discard statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch   <= 16'h0000;
      stat_discard <= 16'h0000;
    end else begin
      if (push_s && (stat_fetch != 16'hFFFF)) begin
        stat_fetch <= stat_fetch + 16'd1;
      end
      if (drop_s && (stat_discard != 16'hFFFF)) begin
        stat_discard <= stat_discard + 16'd1;
      end
    end
  end
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif

  assign bus.mem_req    = mem_req_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.count      = count_r;
  assign bus.inst_valid = valid_s;
  assign bus.inst       = valid_s ? fifo_inst_r[rd_ptr_r] : NOP;
  assign bus.inst_pc    = valid_s ? fifo_pc_r[rd_ptr_r]   : 32'h0000_0000;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch_buffer
// Directed scenarios (reset, fill, streaming, redirect while idle / waiting /
// on ack, reset with a late ack) followed by randomized traffic checked
// against a stream model: after any redirect or reset the CPU must see the
// words target, target+4, ... in order, each equal to the memory contents.
// ---------------------------------------------------------------------------
module tb_inst_prefetch_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  logic [31:0] exp_pc = 32'h0;

  inst_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetch;
  logic [15:0] stat_discard;
`endif

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetch(stat_fetch),
    .stat_discard(stat_discard)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: a fixed scramble of the address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},    32'(bus.mem_req),    32'd0);
    chk({tag, "_mem_addr"},   bus.mem_addr,        32'h0);
    chk({tag, "_count"},      32'(bus.count),      32'd0);
    chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"},       bus.inst,            NOP);
    chk({tag, "_inst_pc"},    bus.inst_pc,         32'h0);
  endtask

  // One cycle of traffic plus stream-model and invariant checks
  task automatic cyc(input logic ready, input logic redir, input logic [31:0] rpc,
                     input logic ack);
    logic        hold;
    logic [31:0] held;
    bus.inst_ready  = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.mem_ack     = ack;
    bus.mem_rdata   = bus.mem_req ? word_at(bus.mem_addr) : $urandom;
    if (redir) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
    end else if (bus.inst_valid && ready) begin
      chk("rnd_pop_pc", bus.inst_pc, exp_pc);
      chk("rnd_pop_inst", bus.inst, word_at(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    hold = bus.mem_req & ~ack;
    held = bus.mem_addr;
    tick();
    chk("rnd_count_max", 32'(bus.count <= CW'(DEPTH)), 32'd1);
    if (!bus.inst_valid) begin
      chk("rnd_empty_count", 32'(bus.count), 32'd0);
      chk("rnd_empty_inst", bus.inst, NOP);
      chk("rnd_empty_pc", bus.inst_pc, 32'h0);
    end
    chk("rnd_addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
    if (hold) begin
      chk("rnd_req_held", 32'(bus.mem_req), 32'd1);
      chk("rnd_addr_held", bus.mem_addr, held);
    end
  endtask

  initial begin
    int n;
    int pops_before;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // T1: zero-wait fill with the CPU stalled
    tick();
    chk("t1_req_rise", 32'(bus.mem_req), 32'd1);
    chk("t1_addr0", bus.mem_addr, 32'h0);
    chk("t1_not_valid", 32'(bus.inst_valid), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word_at(bus.mem_addr);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_addr", bus.mem_addr, 32'(4 * i));
      chk("t1_count", 32'(bus.count), 32'(i));
      chk("t1_req", 32'(bus.mem_req), 32'd1);
      bus.mem_rdata = word_at(bus.mem_addr);
    end
    tick();
    chk("t1_full_req", 32'(bus.mem_req), 32'd0);
    chk("t1_full_count", 32'(bus.count), 32'd4);
    chk("t1_head_pc", bus.inst_pc, 32'h0);
    chk("t1_head_inst", bus.inst, word_at(32'h0));
    tick();
    chk("t1_idle_count", 32'(bus.count), 32'd4);
    chk("t1_idle_req", 32'(bus.mem_req), 32'd0);

    // T2: streaming, one word per cycle
    bus.inst_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.mem_rdata = word_at(bus.mem_addr);
      tick();
      chk("t2_pc", bus.inst_pc, 32'(4 * k));
      chk("t2_inst", bus.inst, word_at(32'(4 * k)));
      chk("t2_valid", 32'(bus.inst_valid), 32'd1);
      chk("t2_count_max", 32'(bus.count <= CW'(DEPTH)), 32'd1);
      if (k == 1) begin
        chk("t2_restart_req", 32'(bus.mem_req), 32'd1);
        chk("t2_restart_addr", bus.mem_addr, 32'd16);
      end
    end
    bus.inst_ready = 1'b0;
    n = 0;
    while (bus.mem_req && n < 20) begin
      bus.mem_rdata = word_at(bus.mem_addr);
      tick();
      n++;
    end
    chk("t2_refill_timeout", 32'(bus.mem_req), 32'd0);
    chk("t2_refill_count", 32'(bus.count), 32'd4);
    chk("t2_refill_head", bus.inst_pc, 32'd32);

    // T3: redirect while full and idle
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    bus.mem_ack  = 1'b0;
    chk("t3_count", 32'(bus.count), 32'd0);
    chk("t3_valid", 32'(bus.inst_valid), 32'd0);
    chk("t3_nop", bus.inst, NOP);
    chk("t3_pc0", bus.inst_pc, 32'h0);
    tick();
    chk("t3_req", 32'(bus.mem_req), 32'd1);
    chk("t3_addr", bus.mem_addr, 32'h100);

    // T4: redirect during a 3-cycle memory wait
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect = 1'b0;
    chk("t4_hold_req", 32'(bus.mem_req), 32'd1);
    chk("t4_hold_addr", bus.mem_addr, 32'h100);
    tick();
    chk("t4_hold_addr2", bus.mem_addr, 32'h100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word_at(32'h100);
    tick();
    bus.mem_ack = 1'b0;
    chk("t4_drop_count", 32'(bus.count), 32'd0);
    chk("t4_drop_valid", 32'(bus.inst_valid), 32'd0);
    chk("t4_drop_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("t4_reissue_req", 32'(bus.mem_req), 32'd1);
    chk("t4_reissue_addr", bus.mem_addr, 32'h200);
`ifdef PREFETCH_STATS_EN
    chk("t4_stat_discard", 32'(stat_discard), 32'd1);
`endif

    // T5: redirect on the same cycle as mem_ack
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word_at(32'h200);
    tick();
    chk("t5_push_pc", bus.inst_pc, 32'h200);
    chk("t5_push_count", 32'(bus.count), 32'd1);
    chk("t5_next_addr", bus.mem_addr, 32'h204);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    bus.mem_rdata   = word_at(32'h204);
    tick();
    bus.redirect = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_valid", 32'(bus.inst_valid), 32'd0);
    chk("t5_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("t5_req2", 32'(bus.mem_req), 32'd1);
    chk("t5_addr", bus.mem_addr, 32'h40);
    bus.mem_rdata = word_at(32'h40);
    tick();
    bus.mem_ack = 1'b0;
    chk("t5_target_valid", 32'(bus.inst_valid), 32'd1);
    chk("t5_target_pc", bus.inst_pc, 32'h40);
    chk("t5_target_inst", bus.inst, word_at(32'h40));
`ifdef PREFETCH_STATS_EN
    chk("t5_stat_discard", 32'(stat_discard), 32'd2);
`endif

    // T6: reset during an outstanding request, late ack afterwards
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6");
`ifdef PREFETCH_STATS_EN
    chk("t6_stat_fetch", 32'(stat_fetch), 32'd0);
    chk("t6_stat_discard", 32'(stat_discard), 32'd0);
`endif
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    chk("t6_late_count", 32'(bus.count), 32'd0);
    chk("t6_resume_req", 32'(bus.mem_req), 32'd1);
    chk("t6_resume_addr", bus.mem_addr, 32'h0);
    tick();
    chk("t6_late_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_late_count2", 32'(bus.count), 32'd0);

    // Randomized traffic against the stream model
    exp_pc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), $urandom,
          1'($urandom_range(0, 1)));
    end

    // Redirect near the top of the address space and drain through the wrap
    pops_before = pops;
    cyc(1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
    end
    chk("drain_progress", 32'((pops - pops_before) >= 8), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
